jtag_debug_cmd_bridge: RTL
==========================

JTAG_DEBUG_CMD_BRIDGE -- requirements
Module: jtag_debug_cmd_bridge

Interface
REQ-001 SHALL have parameter SR_WIDTH, default 38, width of the scan register and of cmd_data.
REQ-002 SHALL have parameter IR_WIDTH, default 2, width of the instruction register; channel count NCH = 2**IR_WIDTH.
REQ-003 SHALL have parameter DEPTH, default 4, command FIFO depth; power of 2, at least 2.
REQ-004 SHALL have parameter ACT_BIT, default SR_WIDTH-1, the sr bit that selects action vs no-action.
REQ-005 SHALL have parameter FLUSH_ON_UIR, default 1; 1 = an update-IR event discards all queued commands.
REQ-006 SHALL use one clock and a synchronous, active-low reset: port clk (input, 1) and port reset_n (input, 1).
REQ-007 SHALL have these ports:
- ir_in, input, IR_WIDTH: instruction register from the JTAG domain; held stable around update strobes.
- sr, input, SR_WIDTH: scan register from the JTAG domain; held stable around update strobes.
- vs_udr, input, 1: update-DR strobe, asynchronous to clk.
- vs_uir, input, 1: update-IR strobe, asynchronous to clk.
- cmd_valid, output, 1: FIFO head is valid.
- cmd_ready, input, 1: consumer accepts the head.
- cmd_ir, output, IR_WIDTH: instruction of the head entry.
- cmd_data, output, SR_WIDTH: scan data of the head entry (jdo).
- take_action, output, NCH: one-hot pulse on pop when the action bit is 1.
- take_no_action, output, NCH: one-hot pulse on pop when the action bit is 0.
- uir_seen, output, 1: one-cycle pulse per update-IR event.
- overflow, output, 1: sticky flag, a command was dropped.
- clear_overflow, input, 1: clears overflow.
- fifo_level, output, clog2(DEPTH+1): count of queued entries.

Function
REQ-008 SHALL pass vs_udr and vs_uir each through a 3-flop chain (s1, s2, s3); the event is s2 & ~s3.
REQ-009 On a udr event, SHALL write {ir_in, sr}, sampled in that cycle, into the FIFO tail if not full.
REQ-010 cmd_valid SHALL rise on the 3rd rising clk edge after vs_udr is first sampled high, when the FIFO starts empty.
REQ-011 SHALL be a show-ahead FIFO: cmd_ir and cmd_data present the head combinationally from storage.
REQ-012 cmd_ir and cmd_data SHALL read all-zero when cmd_valid = 0.
REQ-013 A pop SHALL occur when cmd_valid & cmd_ready; cmd_ready while empty SHALL have no effect.
REQ-014 In the pop cycle, SHALL assert take_action[cmd_ir] if cmd_data[ACT_BIT] = 1, else take_no_action[cmd_ir], for exactly one cycle; both vectors SHALL be zero otherwise.
REQ-015 Push while full with no pop SHALL drop the new entry and set overflow; FIFO contents SHALL be unchanged.
REQ-016 Push and pop in the same cycle when full SHALL accept both; fifo_level stays DEPTH and overflow is not set.
REQ-017 Push and pop in the same cycle when non-full and non-empty SHALL leave fifo_level unchanged.
REQ-018 Read and write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH; full and empty SHALL be derived from fifo_level.
REQ-019 A uir event SHALL pulse uir_seen for one cycle.
REQ-020 When FLUSH_ON_UIR = 1, a uir event SHALL empty the FIFO and suppress any pop and its action pulses in that cycle.
REQ-021 When uir and udr events coincide, SHALL flush first, then push; fifo_level becomes 1.
REQ-022 overflow SHALL stay set until clear_overflow = 1; if clear and a set coincide, set wins.
REQ-023 An overflow drop SHALL never alter an entry already queued.

Reset
REQ-024 While reset_n = 0 at a clk edge, SHALL clear all sync flops, pointers, fifo_level and overflow.
REQ-025 During reset, cmd_valid, take_action, take_no_action and uir_seen SHALL be 0, and cmd_ir and cmd_data SHALL be all-zero.
REQ-026 Reset asserted mid-operation SHALL discard queued entries; a vs_udr held high through reset release SHALL produce exactly one event.
REQ-027 FIFO storage SHALL need no reset.

Verification
REQ-028 One command: ir_in=2, sr[37]=1, sr[31:0]=0xDEADBEEF, vs_udr pulse, cmd_ready=1 -> cmd_valid at edge 3, then take_action=4'b0100 for 1 cycle, fifo_level returns to 0.
REQ-029 No-action path: ir_in=1, sr[37]=0 -> take_no_action=4'b0010, take_action=0.
REQ-030 Overflow: 5 udr events with cmd_ready=0 -> fifo_level=4, overflow=1, first 4 entries pop in order; clear_overflow -> overflow=0.
REQ-031 Full with simultaneous pop and push -> level stays 4, overflow=0, new entry popped last; pointer wrap covered over more than 8 entries.
REQ-032 Flush: 3 entries queued, then vs_uir pulse -> uir_seen pulse, fifo_level=0, no action pulses; with coincident udr -> level=1.
REQ-033 Reset with 2 entries queued -> after release, cmd_valid=0, level=0, overflow=0, cmd_data=0.

Source files
------------

// File: rtl/jtag_debug_cmd_bridge.sv
// rtl/jtag_debug_cmd_bridge.sv - JTAG update-strobe synchroniser feeding a show-ahead command FIFO
module jtag_debug_cmd_bridge #(
  parameter int SR_WIDTH     = 38,
  parameter int IR_WIDTH     = 2,
  parameter int DEPTH        = 4,
  parameter int ACT_BIT      = SR_WIDTH - 1,
  parameter int FLUSH_ON_UIR = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [IR_WIDTH-1:0]            ir_in,
  input  logic [SR_WIDTH-1:0]            sr,
  input  logic                           vs_udr,
  input  logic                           vs_uir,
  output logic                           cmd_valid,
  input  logic                           cmd_ready,
  output logic [IR_WIDTH-1:0]            cmd_ir,
  output logic [SR_WIDTH-1:0]            cmd_data,
  output logic [(2**IR_WIDTH)-1:0]       take_action,
  output logic [(2**IR_WIDTH)-1:0]       take_no_action,
  output logic                           uir_seen,
  output logic                           overflow,
  input  logic                           clear_overflow,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_level
);

  localparam int NCH = 2**IR_WIDTH;
  localparam int LW  = $clog2(DEPTH+1);
  localparam int PW  = $clog2(DEPTH);
  localparam int EW  = IR_WIDTH + SR_WIDTH;

  // Synchroniser chains: bit0 = s1, bit1 = s2, bit2 = s3
  logic [2:0]    udr_sync_q, uir_sync_q;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [EW-1:0] mem_q [DEPTH];

  logic          udr_ev, uir_ev, flush;
  logic          full, empty, valid, pop, push_ok, drop;
  logic [EW-1:0] head;

  assign udr_ev  = udr_sync_q[1] & ~udr_sync_q[2];
  assign uir_ev  = uir_sync_q[1] & ~uir_sync_q[2];
  assign flush   = (FLUSH_ON_UIR != 0) && uir_ev;
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign valid   = reset_n && !empty;
  // A flush cancels the pop so no stale command is acted on
  assign pop     = valid && cmd_ready && !flush;
  // Flush empties the queue first, so a coincident push always lands
  assign push_ok = udr_ev && (flush || !full || pop);
  assign drop    = udr_ev && !flush && full && !pop;
  assign head    = mem_q[rptr_q];

  // Next-state for pointers, level and the sticky overflow flag
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (flush) begin
      rptr_d  = wptr_q;
      level_d = push_ok ? LW'(1) : '0;
    end else begin
      if (pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      case ({push_ok, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  // Control state: synchronisers, pointers, level, overflow
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      udr_sync_q <= '0;
      uir_sync_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      udr_sync_q <= {udr_sync_q[1:0], vs_udr};
      uir_sync_q <= {uir_sync_q[1:0], vs_uir};
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Command storage: written only on an accepted push, never reset
  always_ff @(posedge clk) begin
    if (reset_n && push_ok) begin
      mem_q[wptr_q] <= {ir_in, sr};
    end
  end

  assign cmd_valid      = valid;
  assign cmd_ir         = valid ? head[EW-1:SR_WIDTH] : '0;
  assign cmd_data       = valid ? head[SR_WIDTH-1:0] : '0;
  assign take_action    = (pop &&  head[ACT_BIT]) ? (NCH'(1) << cmd_ir) : '0;
  assign take_no_action = (pop && !head[ACT_BIT]) ? (NCH'(1) << cmd_ir) : '0;
  assign uir_seen       = reset_n && uir_ev;
  assign overflow       = overflow_q;
  assign fifo_level     = level_q;

endmodule
